// File: rtl/spi_rx_registers.sv
// Write-only Mode 0 SPI slave holding the wavetable synthesizer configuration.
// SPI pins are synchronized into clk; the first byte of a frame is the address, later bytes burst-write.
`timescale 1ns/1ps

module spi_rx_registers (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_mosi,
    input  logic       spi_sck,
    input  logic       spi_cs,
    input  logic       status_gate_active,
    input  logic       status_osc_running,
    output logic [7:0] reg_control,
    output logic [7:0] reg_freq_low,
    output logic [7:0] reg_freq_mid,
    output logic [7:0] reg_freq_high,
    output logic [7:0] reg_volume,
    output logic [7:0] reg_wavetable_0,
    output logic [7:0] reg_wavetable_1,
    output logic [7:0] reg_wavetable_2,
    output logic [7:0] reg_wavetable_3,
    output logic [7:0] reg_wavetable_4,
    output logic [7:0] reg_wavetable_5,
    output logic [7:0] reg_wavetable_6,
    output logic [7:0] reg_wavetable_7,
    output logic [7:0] reg_status
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    state_t     state;
    logic       sck_meta, sck_sync, sck_prev;
    logic       cs_meta, cs_sync;
    logic       mosi_meta, mosi_sync;
    logic [1:0] sync_fill;
    logic       frame_armed;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic [7:0] addr;

    logic       sck_rise;
    logic       byte_done;
    logic [7:0] next_byte;
    logic       wr_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            sck_meta  <= spi_sck;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            cs_meta   <= spi_cs;
            cs_sync   <= cs_meta;
            mosi_meta <= spi_mosi;
            mosi_sync <= mosi_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign sck_rise  = sck_sync & ~sck_prev;
    assign next_byte = {shift_reg[6:0], mosi_sync};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign wr_en     = (state == ST_DATA) && !cs_sync && byte_done;

    // frame_armed only sets once the synchronizer holds real CS samples, so a
    // reset taken while CS is low never picks up the tail of an aborted frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shift_reg   <= 8'h00;
            bit_cnt     <= 3'd0;
            addr        <= 8'h00;
            frame_armed <= 1'b0;
        end else if (cs_sync) begin
            state     <= ST_IDLE;
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
            if (sync_fill[1]) begin
                frame_armed <= 1'b1;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_armed) begin
                        state     <= ST_ADDR;
                        shift_reg <= 8'h00;
                        bit_cnt   <= 3'd0;
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        shift_reg <= next_byte;
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            addr  <= next_byte;
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sck_rise) begin
                        shift_reg <= next_byte;
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            addr <= addr + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Unmapped addresses fall through the case and leave every register untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_control     <= 8'h00;
            reg_freq_low    <= 8'h00;
            reg_freq_mid    <= 8'h00;
            reg_freq_high   <= 8'h00;
            reg_volume      <= 8'h00;
            reg_wavetable_0 <= 8'h00;
            reg_wavetable_1 <= 8'h00;
            reg_wavetable_2 <= 8'h00;
            reg_wavetable_3 <= 8'h00;
            reg_wavetable_4 <= 8'h00;
            reg_wavetable_5 <= 8'h00;
            reg_wavetable_6 <= 8'h00;
            reg_wavetable_7 <= 8'h00;
        end else if (wr_en) begin
            case (addr)
                8'h00:   reg_control     <= next_byte;
                8'h02:   reg_freq_low    <= next_byte;
                8'h03:   reg_freq_mid    <= next_byte;
                8'h04:   reg_freq_high   <= next_byte;
                8'h05:   reg_volume      <= next_byte;
                8'h10:   reg_wavetable_0 <= next_byte;
                8'h11:   reg_wavetable_1 <= next_byte;
                8'h12:   reg_wavetable_2 <= next_byte;
                8'h13:   reg_wavetable_3 <= next_byte;
                8'h14:   reg_wavetable_4 <= next_byte;
                8'h15:   reg_wavetable_5 <= next_byte;
                8'h16:   reg_wavetable_6 <= next_byte;
                8'h17:   reg_wavetable_7 <= next_byte;
                default: ;
            endcase
        end
    end

    assign reg_status = {6'b000000, status_osc_running, status_gate_active};

endmodule

// File: tb/tb_spi_rx_registers.sv
// Randomized scoreboard bench for spi_rx_registers: frames update a register-image model,
// expected register changes are queued, and a monitor checks every observed change.
`timescale 1ns/1ps

module tb_spi_rx_registers;

    localparam int  CLK_HALF    = 10;
    localparam time LATENCY_MAX = 90;

    typedef struct {
        int         idx;
        logic [7:0] val;
        time        t_edge;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_mosi;
    logic       spi_sck;
    logic       spi_cs;
    logic       status_gate_active;
    logic       status_osc_running;
    logic [7:0] reg_control, reg_freq_low, reg_freq_mid, reg_freq_high, reg_volume;
    logic [7:0] reg_wavetable_0, reg_wavetable_1, reg_wavetable_2, reg_wavetable_3;
    logic [7:0] reg_wavetable_4, reg_wavetable_5, reg_wavetable_6, reg_wavetable_7;
    logic [7:0] reg_status;

    logic [7:0] dut_img   [13];
    logic [7:0] prev_img  [13];
    logic [7:0] model_img [13];
    logic [7:0] frame_q   [$];
    exp_t       exp_q     [$];
    int         n_vec = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;

    always #CLK_HALF clk = ~clk;

    spi_rx_registers dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .spi_mosi           (spi_mosi),
        .spi_sck            (spi_sck),
        .spi_cs             (spi_cs),
        .status_gate_active (status_gate_active),
        .status_osc_running (status_osc_running),
        .reg_control        (reg_control),
        .reg_freq_low       (reg_freq_low),
        .reg_freq_mid       (reg_freq_mid),
        .reg_freq_high      (reg_freq_high),
        .reg_volume         (reg_volume),
        .reg_wavetable_0    (reg_wavetable_0),
        .reg_wavetable_1    (reg_wavetable_1),
        .reg_wavetable_2    (reg_wavetable_2),
        .reg_wavetable_3    (reg_wavetable_3),
        .reg_wavetable_4    (reg_wavetable_4),
        .reg_wavetable_5    (reg_wavetable_5),
        .reg_wavetable_6    (reg_wavetable_6),
        .reg_wavetable_7    (reg_wavetable_7),
        .reg_status         (reg_status)
    );

    assign dut_img[0]  = reg_control;
    assign dut_img[1]  = reg_freq_low;
    assign dut_img[2]  = reg_freq_mid;
    assign dut_img[3]  = reg_freq_high;
    assign dut_img[4]  = reg_volume;
    assign dut_img[5]  = reg_wavetable_0;
    assign dut_img[6]  = reg_wavetable_1;
    assign dut_img[7]  = reg_wavetable_2;
    assign dut_img[8]  = reg_wavetable_3;
    assign dut_img[9]  = reg_wavetable_4;
    assign dut_img[10] = reg_wavetable_5;
    assign dut_img[11] = reg_wavetable_6;
    assign dut_img[12] = reg_wavetable_7;

    // Register map of the synthesizer: image slot for an SPI address, -1 if unmapped.
    function automatic int map_idx(input logic [7:0] a);
        if (a == 8'h00) return 0;
        if (a >= 8'h02 && a <= 8'h05) return int'(a) - 1;
        if (a >= 8'h10 && a <= 8'h17) return int'(a) - 16 + 5;
        return -1;
    endfunction

    // Any register change must match the oldest queued write, within the latency bound.
    always @(negedge clk) begin
        int   nchg;
        int   chg_idx;
        exp_t e;
        if (!mon_en) begin
            for (int i = 0; i < 13; i++) prev_img[i] = dut_img[i];
        end else begin
            nchg    = 0;
            chg_idx = -1;
            for (int i = 0; i < 13; i++) begin
                if (dut_img[i] !== prev_img[i]) begin
                    nchg++;
                    chg_idx = i;
                end
            end
            if (nchg > 0) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_write: slot %0d now 0x%02h, no write expected",
                             chg_idx, dut_img[chg_idx]);
                end else begin
                    e = exp_q.pop_front();
                    if (nchg != 1 || chg_idx != e.idx || dut_img[e.idx] !== e.val) begin
                        n_fail++;
                        $display("[TB] FAIL write_target: got %0d changes, last slot %0d = 0x%02h; required slot %0d = 0x%02h",
                                 nchg, chg_idx, dut_img[chg_idx], e.idx, e.val);
                    end else if ($time - e.t_edge > LATENCY_MAX) begin
                        n_fail++;
                        $display("[TB] FAIL write_latency: slot %0d seen %0t after SCK edge, required <= %0t",
                                 e.idx, $time - e.t_edge, LATENCY_MAX);
                    end
                end
                for (int i = 0; i < 13; i++) prev_img[i] = dut_img[i];
            end
        end
    end

    task automatic sendRawBits(input logic [7:0] b, input int nbits, input int half);
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = b[i];
            repeat (half) @(negedge clk);
            spi_sck = 1'b1;
            repeat (half) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    // Sends frame_q as one frame; the last byte is cut to last_bits bits.
    task automatic applyStimulus(input int last_bits, input int half);
        logic [7:0] addr;
        int         idx;
        int         nb;
        addr = 8'h00;
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        foreach (frame_q[k]) begin
            nb = (k == frame_q.size() - 1) ? last_bits : 8;
            for (int i = 7; i >= 8 - nb; i--) begin
                spi_mosi = frame_q[k][i];
                repeat (half) @(negedge clk);
                spi_sck = 1'b1;
                if (i == 0) begin
                    if (k == 0) begin
                        addr = frame_q[k];
                    end else begin
                        idx = map_idx(addr);
                        if (idx >= 0) begin
                            if (model_img[idx] != frame_q[k])
                                exp_q.push_back('{idx, frame_q[k], $time});
                            model_img[idx] = frame_q[k];
                        end
                        addr = addr + 8'd1;
                    end
                end
                repeat (half) @(negedge clk);
                spi_sck = 1'b0;
            end
        end
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) @(negedge clk);
        n_vec++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("[TB] FAIL drain_timeout: %0d writes still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic checkOutput(input string name);
        for (int i = 0; i < 13; i++) begin
            n_vec++;
            if (dut_img[i] !== model_img[i]) begin
                n_fail++;
                $display("[TB] FAIL %s slot %0d: got 0x%02h, required 0x%02h",
                         name, i, dut_img[i], model_img[i]);
            end
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    task automatic checkStatus(input logic gate, input logic osc);
        status_gate_active = gate;
        status_osc_running = osc;
        #1;
        checkValue("status", {24'h0, reg_status}, 32'(int'(osc) * 2 + int'(gate)));
    endtask

    task automatic doReset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) model_img[i] = 8'h00;
        exp_q.delete();
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    initial begin
        #1_600_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        int last_bits;
        logic [7:0] a;

        rst_n = 1'b1;
        spi_mosi = 1'b0;
        spi_sck = 1'b0;
        spi_cs = 1'b1;
        status_gate_active = 1'b0;
        status_osc_running = 1'b0;
        repeat (2) @(negedge clk);
        doReset();
        checkOutput("reset");
        checkValue("reset_status", {24'h0, reg_status}, 32'h0);

        frame_q = {8'h00, 8'h01};
        applyStimulus(8, 25);
        checkValue("control_1", {24'h0, reg_control}, 32'h01);
        frame_q = {8'h00, 8'h02};
        applyStimulus(8, 25);
        checkValue("control_2", {24'h0, reg_control}, 32'h02);

        frame_q = {8'h02, 8'h00};
        applyStimulus(8, 25);
        frame_q = {8'h03, 8'h40};
        applyStimulus(8, 25);
        frame_q = {8'h04, 8'h02};
        applyStimulus(8, 25);
        checkValue("freq_word", {8'h0, reg_freq_high, reg_freq_mid, reg_freq_low}, 32'h024000);
        frame_q = {8'h05, 8'h80};
        applyStimulus(8, 25);
        checkValue("volume", {24'h0, reg_volume}, 32'h80);

        frame_q = {8'h10, 8'd0, 8'd73, 8'd146, 8'd219, 8'd255, 8'd219, 8'd146, 8'd73};
        applyStimulus(8, 25);
        checkValue("wave_0", {24'h0, reg_wavetable_0}, 32'd0);
        checkValue("wave_4", {24'h0, reg_wavetable_4}, 32'd255);
        checkValue("wave_7", {24'h0, reg_wavetable_7}, 32'd73);
        frame_q = {8'h16, 8'h11, 8'h22, 8'h33};
        applyStimulus(8, 25);
        checkValue("wave_6_burst", {24'h0, reg_wavetable_6}, 32'h11);
        checkValue("wave_7_burst", {24'h0, reg_wavetable_7}, 32'h22);
        checkOutput("burst_past_end");

        frame_q = {8'h06, 8'hA5};
        applyStimulus(8, 25);
        frame_q = {8'h01, 8'h5A};
        applyStimulus(8, 25);
        checkOutput("unmapped");

        frame_q = {8'h05, 8'h3C};
        applyStimulus(5, 25);
        checkValue("partial_byte", {24'h0, reg_volume}, 32'h80);
        frame_q = {8'h05, 8'h3C};
        applyStimulus(8, 25);
        checkValue("after_partial", {24'h0, reg_volume}, 32'h3C);

        frame_q = {8'hFF, 8'hAA, 8'hBB};
        applyStimulus(8, 5);
        checkValue("addr_wrap", {24'h0, reg_control}, 32'hBB);

        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h1F));
            len = $urandom_range(0, 6);
            last_bits = (len > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 8;
            frame_q = {a};
            for (int j = 0; j < len; j++) frame_q.push_back(8'($urandom));
            applyStimulus(last_bits, 5);
            checkOutput("random");
        end

        // Reset taken in the middle of a frame, with CS held low afterwards.
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        sendRawBits(8'h05, 8, 5);
        sendRawBits(8'h99, 3, 5);
        doReset();
        checkOutput("reset_mid_frame");
        sendRawBits(8'h05, 8, 5);
        sendRawBits(8'h55, 8, 5);
        repeat (6) @(negedge clk);
        checkValue("no_decode_after_reset", {24'h0, reg_volume}, 32'h00);
        spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        frame_q = {8'h05, 8'h77};
        applyStimulus(8, 5);
        checkOutput("frame_after_reset");

        checkStatus(1'b1, 1'b1);
        checkStatus(1'b1, 1'b0);
        checkStatus(1'b0, 1'b1);
        checkStatus(1'b0, 1'b0);
        for (int n = 0; n < 6; n++) checkStatus(1'($urandom), 1'($urandom));
        rst_n = 1'b0;
        checkStatus(1'b1, 1'b0);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
